// File: rtl/pipeline_ctrl_unit.sv
// rtl/pipeline_ctrl_unit.sv - hazard/stall/flush sequencing and debug run-step-halt FSM for the 5-stage pipeline
module pipeline_ctrl_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic             ex_wb_reg_write,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_write_reg,
  input  logic             dbg_run,
  input  logic             dbg_step,
  output logic             pipe_enable,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  // Drain counter only has to hold DRAIN_CYCLES-1.
  localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [DW-1:0] drain_cnt;
  logic          step_mode;   // current RUN visit was entered by a single step
  logic          in_run;
  logic          ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic          load_use, br_alu, br_load, stall, halt_go;

  // Register-match terms; r0 is never a real dependency.
  always_comb begin
    in_run     = (state == S_RUN);
    ex_rs_hit  = (ex_write_reg  != 5'd0) && (ex_write_reg  == id_rs);
    ex_rt_hit  = (ex_write_reg  != 5'd0) && (ex_write_reg  == id_rt);
    mem_rs_hit = (mem_write_reg != 5'd0) && (mem_write_reg == id_rs);
    mem_rt_hit = (mem_write_reg != 5'd0) && (mem_write_reg == id_rt);
    load_use   = ex_mem_read && (ex_rs_hit || (id_uses_rt && ex_rt_hit));
    br_alu     = id_is_branch && ex_wb_reg_write && (ex_rs_hit || ex_rt_hit);
    br_load    = id_is_branch && mem_mem_read && (mem_rs_hit || mem_rt_hit);
    stall      = in_run && (load_use || br_alu || br_load);
    halt_go    = in_run && id_halt && !stall;
  end

  // Per-state pipeline enables; in RUN the hazard priority is stall > halt > taken branch.
  always_comb begin
    pipe_enable  = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state)
      S_RUN: begin
        pipe_enable = 1'b1;
        if (stall) begin
          id_ex_bubble = 1'b1;
        end else if (id_halt) begin
          // HALT itself moves on into ID_EX; nothing behind it is fetched.
          if_id_flush = 1'b1;
        end else if (id_is_branch && id_branch_taken) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      S_DRAIN: begin
        pipe_enable = 1'b1;
        if_id_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Debug FSM: IDLE/RUN/DRAIN/HALTED with one-cycle step visits to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      step_mode <= 1'b0;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dbg_run) begin
            state     <= S_RUN;
            step_mode <= 1'b0;
          end else if (dbg_step) begin
            state     <= S_RUN;
            step_mode <= 1'b1;
          end
        end
        S_RUN: begin
          if (halt_go) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
            step_mode <= 1'b0;
          end else if (step_mode || !dbg_run) begin
            state     <= S_IDLE;
            step_mode <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: begin
          halted <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb/tb_pipeline_ctrl_unit.sv - scoreboard bench for pipeline_ctrl_unit
module tb_pipeline_ctrl_unit;

  localparam int CNT_W = 3;
  localparam int SAT   = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_write_reg, mem_write_reg;
  logic             id_uses_rt, id_is_branch, id_branch_taken, id_halt;
  logic             ex_mem_read, ex_wb_reg_write, mem_mem_read;
  logic             dbg_run, dbg_step;
  logic             pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;

  logic [23:0] exp_q[$];
  logic [23:0] got, want;
  int          vectors = 0;
  int          miscompares = 0;
  int          sc = 0;

  pipeline_ctrl_unit #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_halt(id_halt),
    .ex_mem_read(ex_mem_read), .ex_wb_reg_write(ex_wb_reg_write), .ex_write_reg(ex_write_reg),
    .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
    .dbg_run(dbg_run), .dbg_step(dbg_step),
    .pipe_enable(pipe_enable), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .halted(halted),
    .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic pe, input logic pw, input logic iw,
                                     input logic fl, input logic bb, input logic h,
                                     input logic [1:0] st, input int cnt);
    logic [15:0] c16;
    c16 = 16'(cnt);
    return {pe, pw, iw, fl, bb, h, st, c16};
  endfunction

  function automatic logic [23:0] outs();
    return {pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, state,
            16'(stall_count)};
  endfunction

  // Expected RUN outputs for an ordinary or stalled cycle.
  function automatic logic [23:0] run_exp(input logic stl, input int cnt);
    return stl ? mk(1, 0, 0, 0, 1, 0, 1, cnt) : mk(1, 1, 1, 0, 0, 0, 1, cnt);
  endfunction

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_branch = 0; id_branch_taken = 0;
    id_halt = 0; ex_mem_read = 0; ex_wb_reg_write = 0; ex_write_reg = 0;
    mem_mem_read = 0; mem_write_reg = 0;
  endtask

  function automatic int inc_sat(input int c);
    return (c < SAT) ? c + 1 : SAT;
  endfunction

  task automatic test_reset();
    reset = 1'b1; dbg_run = 1'b1; dbg_step = 1'b1; clr_in();
    id_rs = 5; ex_mem_read = 1; ex_write_reg = 5;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    got = outs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset: got %h want %h", got, want);
    end
    @(negedge clk); reset = 1'b0; dbg_run = 1'b0; dbg_step = 1'b0; clr_in();
  endtask

  task automatic test_run();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      dbg_run = 1'b1;
      exp_q.push_back(c == 0 ? mk(0, 0, 0, 0, 0, 0, 0, sc) : run_exp(1'b0, sc));
      #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL run c%0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    logic stl;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clr_in();
      case (c)
        0: begin ex_mem_read = 1; ex_write_reg = 5; id_rs = 5; stl = 1; end
        1: stl = 0;
        2: begin ex_mem_read = 1; ex_write_reg = 0; id_rs = 0; stl = 0; end
        3: begin ex_mem_read = 1; ex_write_reg = 7; id_rt = 7; id_rs = 3; stl = 0; end
        4: begin ex_mem_read = 1; ex_write_reg = 7; id_rt = 7; id_rs = 3; id_uses_rt = 1; stl = 1; end
        default: stl = 0;
      endcase
      exp_q.push_back(run_exp(stl, sc));
      if (stl) sc = inc_sat(sc);
      #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL load_use c%0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_branch();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clr_in();
      id_is_branch = 1; id_rs = 1; id_rt = 8;
      case (c)
        0: begin ex_wb_reg_write = 1; ex_write_reg = 8;
                 exp_q.push_back(run_exp(1'b1, sc)); sc = inc_sat(sc); end
        1: begin mem_mem_read = 1; mem_write_reg = 8; ex_write_reg = 8;
                 exp_q.push_back(run_exp(1'b1, sc)); sc = inc_sat(sc); end
        2: begin id_branch_taken = 1;
                 exp_q.push_back(mk(1, 1, 1, 1, 0, 0, 1, sc)); end
        3: begin ex_wb_reg_write = 1; ex_write_reg = 0; id_rs = 0;
                 exp_q.push_back(run_exp(1'b0, sc)); end
        default: begin id_is_branch = 0; exp_q.push_back(run_exp(1'b0, sc)); end
      endcase
      #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL branch c%0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      clr_in();
      if (c < 6) begin
        ex_mem_read = 1; ex_write_reg = 5; id_rs = 5;
        exp_q.push_back(run_exp(1'b1, sc)); sc = inc_sat(sc);
      end else begin
        exp_q.push_back(run_exp(1'b0, sc));
      end
      #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL saturate c%0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_step();
    logic run_t[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic step_t[10] = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 0};
    logic [1:0] st_t[10] = '{1, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      clr_in();
      dbg_run = run_t[c]; dbg_step = step_t[c];
      exp_q.push_back(st_t[c] == 2'd1 ? run_exp(1'b0, sc) : mk(0, 0, 0, 0, 0, 0, 0, sc));
      #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL step c%0d: got %h want %h", c, got, want);
      end
    end
    dbg_step = 1'b0;
  endtask

  task automatic test_halt();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      clr_in();
      dbg_run = 1'b1; dbg_step = 1'b0;
      case (c)
        0: begin id_halt = 1; ex_mem_read = 1; ex_write_reg = 5; id_rs = 5;
                 exp_q.push_back(run_exp(1'b1, sc)); sc = inc_sat(sc); end
        1: begin id_halt = 1; exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 1, sc)); end
        2, 4: exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 2, sc));
        3: begin ex_mem_read = 1; ex_write_reg = 5; id_rs = 5;
                 exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 2, sc)); end
        default: begin dbg_run = c[0]; dbg_step = ~c[0];
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 3, sc)); end
      endcase
      #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL halt c%0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    @(negedge clk);
    clr_in(); dbg_run = 1'b0; dbg_step = 1'b0;
    #2 reset = 1'b1; sc = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    got = outs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_halted: got %h want %h", got, want);
    end
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clr_in();
      dbg_run = 1'b1;
      case (c)
        0: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, sc));
        1: begin ex_mem_read = 1; ex_write_reg = 9; id_rs = 9;
                 exp_q.push_back(run_exp(1'b1, sc)); sc = inc_sat(sc); end
        2: begin id_halt = 1; exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 1, sc)); end
        default: exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 2, sc));
      endcase
      #1;
      got = outs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL drain_seq c%0d: got %h want %h", c, got, want);
      end
    end
    #2 reset = 1'b1; sc = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    got = outs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_in_drain: got %h want %h", got, want);
    end
    @(negedge clk); reset = 1'b0; dbg_run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_use();
    test_branch();
    test_saturate();
    test_step();
    test_halt();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
